instr_fetch: RTL

INSTR_FETCH -- requirements
Module: instr_fetch

---
 rtl/fetch_pkg.sv | 24 ++
 rtl/branch_lut.sv | 18 +
 rtl/instr_fetch.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: default widths,
// fetch FSM state type and the constant branch-target table used when
// the TARGET_LUT_EN build option is defined.
package fetch_pkg;

    localparam int unsigned IW_DEF    = 16;
    localparam int unsigned DW_DEF    = 9;
    localparam int unsigned LUT_DEPTH = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    // Absolute branch targets, selected by BranchField[3:0]
    localparam logic [IW_DEF-1:0] BRANCH_TARGETS [LUT_DEPTH] = '{
        16'h0000, 16'h0008, 16'h0020, 16'h0040,
        16'h0080, 16'h0100, 16'h0200, 16'h0400,
        16'h0800, 16'h1000, 16'h2000, 16'h4000,
        16'h8000, 16'hFFF0, 16'hFFFE, 16'hFFFF
    };

endpackage

// File: rtl/branch_lut.sv
// Combinational branch-target lookup table.
// Ports:
//   index  - 4-bit table index (low nibble of the branch operand)
//   target - IW-bit absolute branch target
module branch_lut
    import fetch_pkg::*;
#(
    parameter int unsigned IW = IW_DEF
) (
    input  logic [3:0]    index,
    output logic [IW-1:0] target
);

    always_comb begin
        target = IW'(BRANCH_TARGETS[index]);
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: PC sequencing, one-cycle bubble on taken
// branches, halt/restart control and a registered instruction output.
// Build option: TARGET_LUT_EN selects a constant target table indexed by
// BranchField[3:0]; otherwise the target is PcOut + sign-extended BranchField.
// Ports:
//   Clk, Reset     - clock, synchronous active-high reset
//   Start          - begin execution at address 0 (IDLE/HALTED only)
//   Stall          - freeze all state
//   Halt, BranchEn - decoder flags for the instruction in InstOut
//   Taken          - branch condition result
//   BranchField    - branch operand (LUT index or signed offset)
//   InstAddress    - fetch address to instruction memory (combinational)
//   InstIn         - instruction memory read data for InstAddress
//   InstOut        - registered instruction to the decoder
//   InstValid      - InstOut is a valid, in-path instruction
//   PcOut          - address of the instruction in InstOut
//   Done           - high while halted
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int unsigned IW = IW_DEF,
    parameter int unsigned DW = DW_DEF
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Start,
    input  logic          Stall,
    input  logic          Halt,
    input  logic          BranchEn,
    input  logic          Taken,
    input  logic [7:0]    BranchField,
    output logic [IW-1:0] InstAddress,
    input  logic [DW-1:0] InstIn,
    output logic [DW-1:0] InstOut,
    output logic          InstValid,
    output logic [IW-1:0] PcOut,
    output logic          Done
);

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] pc;
    logic [IW-1:0] pc_nxt;
    logic [IW-1:0] pcout_nxt;
    logic [DW-1:0] inst_nxt;
    logic          valid_nxt;
    logic [IW-1:0] target;
    logic          launch;
    logic          halt_go;
    logic          branch_go;
    logic          advance;

    // Event decode; Halt has priority over a taken branch, and both are
    // ignored while the presented instruction is a bubble.
    assign launch    = !Stall && (state == IDLE || state == HALTED) && Start;
    assign halt_go   = !Stall && (state == RUN) && InstValid && Halt;
    assign branch_go = !Stall && (state == RUN) && InstValid && BranchEn && Taken && !Halt;
    assign advance   = !Stall && (state == RUN);

`ifdef TARGET_LUT_EN
    logic [3:0] unused_field_hi;
    assign unused_field_hi = BranchField[7:4];

    branch_lut #(
        .IW(IW)
    ) u_branch_lut (
        .index (BranchField[3:0]),
        .target(target)
    );
`else
    // Relative target, wrapping modulo 2^IW
    assign target = PcOut + IW'($signed(BranchField));
`endif

    // State register
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (launch) begin
            state_nxt = RUN;
        end else if (halt_go) begin
            state_nxt = HALTED;
        end else if (state != IDLE && state != RUN && state != HALTED) begin
            state_nxt = IDLE;
        end
    end

    // Output and datapath next-value logic
    always_comb begin
        pc_nxt      = pc;
        pcout_nxt   = PcOut;
        inst_nxt    = InstOut;
        valid_nxt   = InstValid;
        InstAddress = pc;
        Done        = (state == HALTED);
        if (launch) begin
            // Restart fetches address 0 directly, regardless of the held PC
            InstAddress = '0;
            pc_nxt      = IW'(1);
            pcout_nxt   = '0;
            inst_nxt    = InstIn;
            valid_nxt   = 1'b1;
        end else if (halt_go) begin
            valid_nxt = 1'b0;
        end else if (branch_go) begin
            // Instruction fetched this cycle is wrong-path: drop it
            pc_nxt    = target;
            valid_nxt = 1'b0;
        end else if (advance) begin
            pc_nxt    = pc + IW'(1);
            pcout_nxt = pc;
            inst_nxt  = InstIn;
            valid_nxt = 1'b1;
        end
    end

    // Datapath registers
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc        <= '0;
            PcOut     <= '0;
            InstOut   <= '0;
            InstValid <= 1'b0;
        end else begin
            pc        <= pc_nxt;
            PcOut     <= pcout_nxt;
            InstOut   <= inst_nxt;
            InstValid <= valid_nxt;
        end
    end

endmodule
